// File: rtl/seq_pkg.sv
// Shared encodings for the SEQ Y86-64 sequencer: icodes, branch conditions,
// status codes and the controller state set.
package seq_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] OPQ_FN_MAX = 4'h3;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_t;

  // Low six bits are the stage enables, so each enable is a flop output.
  typedef enum logic [6:0] {
    S_IDLE      = 7'b0000000,
    S_FETCH     = 7'b0000001,
    S_DECODE    = 7'b0000010,
    S_EXECUTE   = 7'b0000100,
    S_MEMORY    = 7'b0001000,
    S_WRITEBACK = 7'b0010000,
    S_PCUPD     = 7'b0100000,
    S_HALTED    = 7'b1000000
  } state_t;

  function automatic logic is_mem_icode(input logic [3:0] ic);
    return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/cmov condition from the condition codes; also flags ifun values
// that name no condition.
module cond_eval
  import seq_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd_raw,
  output logic       ifun_legal
);

  logic zf, sf, of, lt;

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];
  assign lt = sf ^ of;

  always_comb begin
    cnd_raw    = 1'b0;
    ifun_legal = 1'b1;
    case (ifun)
      C_YES:   cnd_raw = 1'b1;
      C_LE:    cnd_raw = lt | zf;
      C_L:     cnd_raw = lt;
      C_E:     cnd_raw = zf;
      C_NE:    cnd_raw = !zf;
      C_GE:    cnd_raw = !lt;
      C_G:     cnd_raw = !lt & !zf;
      default: ifun_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle SEQ Y86-64 sequencer: one-hot stage enables, CC register,
// condition evaluation, data-memory handshake with timeout, status and retire count.
module seq_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  input  logic             mem_ack,
  output logic             en_fetch,
  output logic             en_decode,
  output logic             en_execute,
  output logic             en_memory,
  output logic             en_writeback,
  output logic             en_pc,
  output logic             mem_req,
  output logic [2:0]       cc,
  output logic             cnd,
  output logic [1:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);
  import seq_pkg::*;

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT - 1);

  state_t        state;
  stat_t         stat_q;
  logic [6:0]    st_bits;
  logic [TW-1:0] tcnt;
  logic          cnd_raw, ifun_legal;
  logic          is_cond;

  cond_eval u_cond (
    .cc         (cc),
    .ifun       (ifun),
    .cnd_raw    (cnd_raw),
    .ifun_legal (ifun_legal)
  );

  assign is_cond = (icode == I_CMOV) || (icode == I_JXX);

  assign st_bits      = state;
  assign en_fetch     = st_bits[0];
  assign en_decode    = st_bits[1];
  assign en_execute   = st_bits[2];
  assign en_memory    = st_bits[3];
  assign en_writeback = st_bits[4];
  assign en_pc        = st_bits[5];
  assign busy         = |st_bits[5:0];
  assign stat         = stat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      stat_q      <= STAT_AOK;
      mem_req     <= 1'b0;
      cc          <= 3'b100;
      cnd         <= 1'b0;
      instr_count <= '0;
      tcnt        <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_FETCH;

        S_FETCH: begin
          if (imem_error) begin
            stat_q <= STAT_ADR;
            state  <= S_HALTED;
          end else if (!instr_valid) begin
            stat_q <= STAT_INS;
            state  <= S_HALTED;
          end else if (icode == I_HALT) begin
            stat_q <= STAT_HLT;
            state  <= S_HALTED;
          end else begin
            state  <= S_DECODE;
          end
        end

        S_DECODE: begin
          if ((is_cond && !ifun_legal) || (icode == I_OPQ && ifun > OPQ_FN_MAX)) begin
            stat_q <= STAT_INS;
            state  <= S_HALTED;
          end else begin
            state  <= S_EXECUTE;
          end
        end

        // cnd_raw is evaluated against the CC value before this cycle's update.
        S_EXECUTE: begin
          if (icode == I_OPQ) cc <= {alu_zf, alu_sf, alu_of};
          cnd     <= is_cond ? cnd_raw : 1'b0;
          mem_req <= is_mem_icode(icode);
          tcnt    <= '0;
          state   <= S_MEMORY;
        end

        // mem_req doubles as "this instruction touches memory"; ack beats timeout.
        S_MEMORY: begin
          if (!mem_req) begin
            state <= S_WRITEBACK;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (dmem_error) begin
              stat_q <= STAT_ADR;
              state  <= S_HALTED;
            end else begin
              state  <= S_WRITEBACK;
            end
          end else if (tcnt == TMAX) begin
            mem_req <= 1'b0;
            stat_q  <= STAT_ADR;
            state   <= S_HALTED;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_WRITEBACK: state <= S_PCUPD;

        S_PCUPD: begin
          instr_count <= instr_count + 1'b1;
          state       <= S_FETCH;
        end

        S_HALTED: state <= S_HALTED;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Randomized bench for seq_ctrl against an instruction-level reference model.
module tb_seq_ctrl;

  localparam int T  = 16;
  localparam int CW = 4;

  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_F    = 6'b000001;
  localparam logic [5:0] E_D    = 6'b000010;
  localparam logic [5:0] E_E    = 6'b000100;
  localparam logic [5:0] E_M    = 6'b001000;
  localparam logic [5:0] E_W    = 6'b010000;
  localparam logic [5:0] E_P    = 6'b100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] icode = 4'h0, ifun = 4'h0;
  logic instr_valid = 1'b1, imem_error = 1'b0, dmem_error = 1'b0;
  logic alu_zf = 1'b0, alu_sf = 1'b0, alu_of = 1'b0, mem_ack = 1'b0;
  logic en_fetch, en_decode, en_execute, en_memory, en_writeback, en_pc;
  logic mem_req, cnd, busy;
  logic [2:0] cc;
  logic [1:0] stat;
  logic [CW-1:0] instr_count;
  logic [5:0] en;

  seq_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .ifun(ifun),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .mem_ack(mem_ack),
    .en_fetch(en_fetch), .en_decode(en_decode), .en_execute(en_execute),
    .en_memory(en_memory), .en_writeback(en_writeback), .en_pc(en_pc),
    .mem_req(mem_req), .cc(cc), .cnd(cnd), .stat(stat), .busy(busy),
    .instr_count(instr_count)
  );

  assign en = {en_pc, en_writeback, en_memory, en_execute, en_decode, en_fetch};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural model
  logic [2:0]    m_cc;
  logic          m_cnd;
  logic [1:0]    m_stat;
  logic [CW-1:0] m_count;
  bit            m_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [2:0] c, input logic [3:0] fn);
    logic z, lt;
    z  = c[2];
    lt = c[1] ^ c[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || z;
      4'd2: return lt;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !lt;
      4'd6: return !lt && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Check the control outputs of the current cycle, then move one cycle on.
  task automatic step(input string tag, input logic [5:0] e, input logic req);
    chk(tag, 32'({en, mem_req, busy}), 32'({e, req, (e != 6'b0)}));
    @(negedge clk);
  endtask

  task automatic arch_chk(input string tag);
    chk({tag, "_cc"},    32'(cc),          32'(m_cc));
    chk({tag, "_cnd"},   32'(cnd),         32'(m_cnd));
    chk({tag, "_stat"},  32'(stat),        32'(m_stat));
    chk({tag, "_count"}, 32'(instr_count), 32'(m_count));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_cc = 3'b100; m_cnd = 1'b0; m_stat = 2'b00; m_count = '0; m_halt = 0;
    chk("rst_ctl", 32'({en, mem_req, busy}), 32'(0));
    arch_chk("rst");
    @(negedge clk);
    rst = 1'b0;
    step("idle_nostart", E_NONE, 1'b0);
    start = 1'b1;
    step("idle_start", E_NONE, 1'b0);
    start = 1'b0;
  endtask

  task automatic expect_halt(input logic [1:0] code);
    m_stat = code;
    m_halt = 1;
    start = 1'b1; mem_ack = 1'b1;
    step("halted", E_NONE, 1'b0);
    step("halted_sticky", E_NONE, 1'b0);
    start = 1'b0; mem_ack = 1'b0;
    arch_chk("halt");
  endtask

  // ack_at: MEMORY cycle (1..T) carrying mem_ack, 0 for never.
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic vld,
                           input logic ierr, input logic [2:0] flags, input int ack_at,
                           input logic derr);
    bit memi;
    bit acked;
    memi = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    icode = ic; ifun = fn; instr_valid = vld; imem_error = ierr;
    mem_ack = 1'($urandom_range(0, 1)); dmem_error = 1'b0;
    step("fetch", E_F, 1'b0);
    instr_valid = 1'b1; imem_error = 1'b0;
    if (ierr)         begin expect_halt(2'b10); return; end
    if (!vld)         begin expect_halt(2'b11); return; end
    if (ic == 4'h0)   begin expect_halt(2'b01); return; end
    {alu_zf, alu_sf, alu_of} = flags;
    step("decode", E_D, 1'b0);
    if (((ic == 4'h2 || ic == 4'h7) && fn > 4'd6) || (ic == 4'h6 && fn > 4'd3)) begin
      expect_halt(2'b11);
      return;
    end
    mem_ack = 1'b0;
    step("execute", E_E, 1'b0);
    m_cnd = (ic == 4'h2 || ic == 4'h7) ? cond_ok(m_cc, fn) : 1'b0;
    if (ic == 4'h6) m_cc = flags;
    if (memi) begin
      acked = 0;
      for (int k = 1; k <= T && !acked; k++) begin
        mem_ack = (k == ack_at);
        dmem_error = derr;
        step("memory", E_M, 1'b1);
        acked = (k == ack_at);
      end
      mem_ack = 1'b0; dmem_error = 1'b0;
      if (!acked || derr) begin expect_halt(2'b10); return; end
    end else begin
      mem_ack = 1'b1; dmem_error = 1'b1;
      step("memory_nomem", E_M, 1'b0);
    end
    mem_ack = 1'($urandom_range(0, 1)); dmem_error = 1'($urandom_range(0, 1));
    step("writeback", E_W, 1'b0);
    step("pcupd", E_P, 1'b0);
    mem_ack = 1'b0; dmem_error = 1'b0;
    m_count = m_count + 1'b1;
    arch_chk("retire");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ic, fn;
    logic vld, ierr, derr;
    int ack, r;

    @(negedge clk);
    // irmovq then halt
    do_reset();
    run_instr(4'h3, 4'h0, 1'b1, 1'b0, 3'b000, 0, 1'b0);
    run_instr(4'h0, 4'h0, 1'b1, 1'b0, 3'b000, 0, 1'b0);

    // subq sets CC, jl taken, jge not taken, mrmovq ack on 3rd cycle, rmmovq timeout
    do_reset();
    run_instr(4'h6, 4'h1, 1'b1, 1'b0, 3'b010, 0, 1'b0);
    run_instr(4'h7, 4'h2, 1'b1, 1'b0, 3'b111, 0, 1'b0);
    run_instr(4'h7, 4'h5, 1'b1, 1'b0, 3'b111, 0, 1'b0);
    run_instr(4'h5, 4'h0, 1'b1, 1'b0, 3'b000, 3, 1'b0);
    run_instr(4'h4, 4'h0, 1'b1, 1'b0, 3'b000, 0, 1'b0);

    // ack coincident with timeout completes; dmem_error on ack halts ADR
    do_reset();
    run_instr(4'h4, 4'h0, 1'b1, 1'b0, 3'b000, T, 1'b0);
    run_instr(4'h9, 4'h0, 1'b1, 1'b0, 3'b000, 1, 1'b1);

    do_reset();
    run_instr(4'h1, 4'h0, 1'b0, 1'b0, 3'b000, 0, 1'b0);

    // illegal cmov ifun after a CC update
    do_reset();
    run_instr(4'h6, 4'h0, 1'b1, 1'b0, 3'b001, 0, 1'b0);
    run_instr(4'h2, 4'h9, 1'b1, 1'b0, 3'b110, 0, 1'b0);

    do_reset();
    run_instr(4'h3, 4'h0, 1'b0, 1'b1, 3'b000, 0, 1'b0);

    // reset in the middle of a memory access
    do_reset();
    run_instr(4'h6, 4'h1, 1'b1, 1'b0, 3'b011, 0, 1'b0);
    icode = 4'h4; ifun = 4'h0;
    step("fetch", E_F, 1'b0);
    step("decode", E_D, 1'b0);
    step("execute", E_E, 1'b0);
    step("memory", E_M, 1'b1);
    chk("mreq_before_rst", 32'(mem_req), 32'(1));
    do_reset();
    run_instr(4'h5, 4'h0, 1'b1, 1'b0, 3'b000, 2, 1'b0);

    // random programs
    for (int p = 0; p < 30; p++) begin
      do_reset();
      for (int n = 0; n < 25 && !m_halt; n++) begin
        ic = 4'($urandom_range(1, 11));
        if ($urandom_range(0, 24) == 0) ic = 4'h0;
        fn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
        if (ic == 4'h6 && $urandom_range(0, 3) != 0) fn = 4'($urandom_range(0, 3));
        vld  = ($urandom_range(0, 39) != 0);
        ierr = ($urandom_range(0, 49) == 0);
        derr = ($urandom_range(0, 24) == 0);
        ack  = $urandom_range(1, 4);
        r    = $urandom_range(0, 19);
        if (r == 0) ack = 0;
        if (r == 1) ack = T;
        run_instr(ic, fn, vld, ierr, 3'($urandom_range(0, 7)), ack, derr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
Multi-cycle sequencer for the SEQ Y86-64 datapath. It steps fetch/decode/execute/memory/writeback/PC-update with one-hot stage enables, and owns the architectural condition-code register (ZF/SF/OF). It also computes the branch/cmov condition cnd from CC and ifun, runs the data-memory request/ack handshake with a timeout, and tracks processor status and the retired-instruction count.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEMORY waiting for mem_ack before ADR error (>=2)
CNT_W, 32, width of instr_count

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin execution from IDLE
icode  in  4  instruction code from fetch, stable from end of FETCH until next FETCH
ifun  in  4  function code from fetch, same timing as icode
instr_valid  in  1  fetch decoded a legal icode
imem_error  in  1  fetch address out of range
dmem_error  in  1  data-memory address error, qualified by mem_ack
alu_zf  in  1  ALU result zero
alu_sf  in  1  ALU result negative
alu_of  in  1  ALU signed overflow
mem_ack  in  1  data memory access complete
en_fetch  out  1  one-hot stage enable
en_decode  out  1  one-hot stage enable
en_execute  out  1  one-hot stage enable
en_memory  out  1  one-hot stage enable
en_writeback  out  1  one-hot stage enable
en_pc  out  1  one-hot stage enable
mem_req  out  1  data memory request
cc  out  3  {zf,sf,of} condition-code register
cnd  out  1  registered condition result
stat  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS
busy  out  1  high in any state except IDLE/HALTED
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async, immediate): state IDLE, all enables 0, mem_req 0, cc=3'b100, cnd 0, stat AOK, busy 0, instr_count 0, timeout counter 0. Reset mid-operation aborts the instruction with no partial CC/count update.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED. The stage enable equals the current state, registered and one-hot. IDLE and HALTED drive no enable.
- IDLE -> FETCH when start=1. start is ignored in all other states.
- FETCH, end of cycle, priority: imem_error -> stat ADR, go HALTED. Else !instr_valid -> INS, go HALTED. Else icode 0 (halt) -> HLT, go HALTED. Else go DECODE.
- DECODE -> EXECUTE after 1 cycle. In DECODE, if icode is 2 or 7 with ifun>6 -> INS, go HALTED. If icode is 6 with ifun>3 -> INS, go HALTED.
- EXECUTE, 1 cycle, at its end:
  - icode 6 (OPq): cc <= {alu_zf,alu_sf,alu_of}.
  - icode 2/7: cnd <= f(cc_old, ifun) using the pre-update cc. ifun 0 always; 1 (sf^of)|zf; 2 sf^of; 3 zf; 4 !zf; 5 !(sf^of); 6 !(sf^of)&!zf.
  - Other icodes: cnd <= 0.
- MEMORY:
  - Memory icodes are 4, 5, 8, 9, A, B. For these, mem_req=1 from the first MEMORY cycle until the cycle mem_ack is seen, inclusive.
  - On ack: dmem_error=1 -> ADR, HALTED. Else go WRITEBACK.
  - If no ack within MEM_TIMEOUT cycles (the counter reaches MEM_TIMEOUT-1 without ack): ADR, HALTED.
  - Ack and timeout in the same cycle: ack wins.
  - Non-memory icodes: 1 cycle, mem_req stays 0.
  - mem_ack outside MEMORY is ignored.
- WRITEBACK -> PCUPD after 1 cycle. PCUPD -> FETCH and instr_count += 1, wrapping modulo 2^CNT_W.
- HALTED is sticky until rst. stat holds its error code, cc/cnd/instr_count are frozen, mem_req is 0.
- Latency: non-memory instruction 6 cycles; memory instruction 5+N cycles, where N is the number of MEMORY cycles through ack.

Decomposition:
- Package seq_pkg: icode constants (HALT=0 … POPQ=B), ifun condition codes, stat encodings, state enum.
- Sub-module cond_eval (combinational): inputs cc, ifun; outputs cnd_raw, ifun_legal. Shared with DECODE's INS check.

Test Plan:
- Reset then start. Program irmovq (icode 3), then halt -> en_* visits F,D,E,M,W,P (6 cycles). instr_count=1. Next FETCH sees icode 0 -> stat 01, HALTED, busy 0.
- OPq subq (6,1) with alu flags {0,1,0}. Then jl (7,2) -> cc=3'b010 after first EXECUTE, cnd=1. Then jge (7,5) -> cnd=0.
- mrmovq (5) with mem_ack after 3 MEMORY cycles -> mem_req high exactly 3 cycles. Total 8 cycles, instr_count +1.
- rmmovq (4), no ack, MEM_TIMEOUT=16 -> mem_req high 16 cycles, then stat 10, HALTED. On a separate run, ack arrives on cycle 16 together with timeout -> completes normally.
- instr_valid=0 at FETCH -> stat 11. Separately, cmov with ifun 9 -> stat 11 from DECODE, cc unchanged.
- Assert rst mid-MEMORY with mem_req=1 -> mem_req 0 with no clock edge, cc=3'b100, count 0, state IDLE. A later start runs normally.
